// File: rtl/axi_ram_responder_pkg.sv
// Shared burst/response codes, FSM state encoding and request validation for
// the AXI RAM responder and its address-step helper.
package axi_ram_responder_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRESP = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

  // A request is rejected (SLVERR) for beats wider than the 64-bit bus,
  // the reserved burst code, or a WRAP whose length is not 2/4/8/16 beats.
  function automatic logic req_error(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic bad_wrap_len;
    bad_wrap_len = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    return (size > 3'd3) || (burst == BURST_RSVD) || ((burst == BURST_WRAP) && bad_wrap_len);
  endfunction

endpackage

// File: rtl/axi_ram_responder_burst_addr.sv
// Combinational next-beat byte address for FIXED / INCR / WRAP bursts.
// Kept standalone so other AXI memory wrappers can reuse it.
module axi_ram_responder_burst_addr
  import axi_ram_responder_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] incr;
  logic [31:0] sum;
  logic [31:0] wrap_mask;

  // INCR steps by the beat size; WRAP keeps the high bits of the aligned window.
  always_comb begin
    incr      = 32'd1 << size;
    sum       = addr + incr;
    wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_INCR: next_addr = sum;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (sum & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 responder in front of a synchronous single-port 64-bit SRAM.
// One transaction at a time; read beats take two cycles (request, then data).
//
// state    | meaning
// IDLE     | waiting for AW/AR, grant alternates when both are valid
// WDATA    | accepting W beats, each written to the SRAM the same cycle
// WRESP    | presenting B until accepted
// RREQ     | issuing the SRAM read for the current beat
// RDATA    | presenting R (captured SRAM data) until accepted
module axi_ram_responder
  import axi_ram_responder_pkg::*;
#(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   i_awid,
  input  logic [31:0]           i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [63:0]           i_wdata,
  input  logic [7:0]            i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [ID_WIDTH-1:0]   o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [31:0]           i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [63:0]           o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic                  o_mem_en,
  output logic [7:0]            o_mem_we,
  output logic [ADDR_WIDTH-4:0] o_mem_addr,
  output logic [63:0]           o_mem_wdata,
  input  logic [63:0]           i_mem_rdata,
  output logic                  o_init_done
);

  state_e              state, state_nx;
  logic [ID_WIDTH-1:0] id_q;
  logic [31:0]         addr_q, addr_nx;
  logic [7:0]          len_q, cnt_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic                last_rd_q;   // last granted direction was a read
  logic                rfirst_q;    // first cycle of RDATA: SRAM output is live
  logic [63:0]         rdata_q;
  logic                init_q;
  logic                grant_w, grant_r, aw_hs, ar_hs, beat_last;

  assign grant_w   = i_awvalid && (!i_arvalid || last_rd_q);
  assign grant_r   = i_arvalid && !grant_w;
  assign aw_hs     = (state == ST_IDLE) && grant_w;
  assign ar_hs     = (state == ST_IDLE) && grant_r;
  assign beat_last = (cnt_q == len_q);

  axi_ram_responder_burst_addr u_burst_addr (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (addr_nx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (aw_hs)      state_nx = ST_WDATA;
        else if (ar_hs) state_nx = ST_RREQ;
      end
      ST_WDATA: if (i_wvalid && beat_last) state_nx = ST_WRESP;
      ST_WRESP: if (i_bready) state_nx = ST_IDLE;
      ST_RREQ:  state_nx = ST_RDATA;
      ST_RDATA: if (i_rready) state_nx = beat_last ? ST_IDLE : ST_RREQ;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Channel handshakes and SRAM strobes per state.
  always_comb begin
    o_awready = 1'b0;
    o_arready = 1'b0;
    o_wready  = 1'b0;
    o_bvalid  = 1'b0;
    o_bresp   = RESP_OKAY;
    o_rvalid  = 1'b0;
    o_rresp   = RESP_OKAY;
    o_rlast   = 1'b0;
    o_mem_en  = 1'b0;
    o_mem_we  = 8'h00;
    case (state)
      ST_IDLE: begin
        o_awready = grant_w;
        o_arready = grant_r;
      end
      ST_WDATA: begin
        o_wready = 1'b1;
        o_mem_en = i_wvalid;
        o_mem_we = (i_wvalid && !err_q) ? i_wstrb : 8'h00;
      end
      ST_WRESP: begin
        o_bvalid = 1'b1;
        o_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      ST_RREQ: o_mem_en = 1'b1;
      ST_RDATA: begin
        o_rvalid = 1'b1;
        o_rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        o_rlast  = beat_last;
      end
      default: ;
    endcase
  end

  assign o_mem_addr  = addr_q[ADDR_WIDTH-1:3];
  assign o_mem_wdata = i_wdata;
  assign o_bid       = id_q;
  assign o_rid       = id_q;
  // SRAM data is only valid in the cycle after the read, so it is forwarded
  // directly then and served from the capture register while R stalls.
  assign o_rdata     = rfirst_q ? (err_q ? 64'd0 : i_mem_rdata) : rdata_q;
  assign o_init_done = init_q;

  // Request capture, beat counting and address stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      last_rd_q <= 1'b1;
    end else if (aw_hs) begin
      id_q      <= i_awid;
      addr_q    <= i_awaddr;
      len_q     <= i_awlen;
      size_q    <= i_awsize;
      burst_q   <= i_awburst;
      cnt_q     <= '0;
      err_q     <= req_error(i_awlen, i_awsize, i_awburst);
      last_rd_q <= 1'b0;
    end else if (ar_hs) begin
      id_q      <= i_arid;
      addr_q    <= i_araddr;
      len_q     <= i_arlen;
      size_q    <= i_arsize;
      burst_q   <= i_arburst;
      cnt_q     <= '0;
      err_q     <= req_error(i_arlen, i_arsize, i_arburst);
      last_rd_q <= 1'b1;
    end else if (state == ST_WDATA && i_wvalid) begin
      cnt_q  <= cnt_q + 8'd1;
      addr_q <= addr_nx;
      if (i_wlast != beat_last) err_q <= 1'b1;
    end else if (state == ST_RDATA && i_rready) begin
      cnt_q  <= cnt_q + 8'd1;
      addr_q <= addr_nx;
    end
  end

  // Read data capture and init-done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfirst_q <= 1'b0;
      rdata_q  <= '0;
      init_q   <= 1'b0;
    end else begin
      rfirst_q <= (state == ST_RREQ);
      if (rfirst_q) rdata_q <= err_q ? 64'd0 : i_mem_rdata;
      init_q   <= 1'b1;
    end
  end

endmodule
